// File: rtl/rdc_prec_ctrl_pkg.sv
// Shared types for the precision-reduction sequencer: element format
// descriptor, default formats and controller FSM states.
package rdc_prec_ctrl_pkg;

  typedef enum logic [1:0] {FXP = 2'd0, FLP = 2'd1} dtype_t;

  typedef struct packed {
    dtype_t      dtype;
    logic        sign;
    int unsigned prec;
    int unsigned frac;
  } dconf_t;

  typedef enum logic [1:0] {RDC_IDLE, RDC_RUN, RDC_DONE} rdc_ctrl_state_t;

  localparam dconf_t I_CONF_DEF = '{dtype: FXP, sign: 1'b1, prec: 16, frac: 4};
  localparam dconf_t O_CONF_DEF = '{dtype: FXP, sign: 1'b1, prec: 8, frac: 3};

endpackage

// File: rtl/rdc_prec_ctrl_if.sv
// Batch-in / batch-out handshake bundle plus per-batch saturation status.
interface rdc_prec_ctrl_if #(
  parameter int NUM    = 8,
  parameter int I_PREC = 16,
  parameter int O_PREC = 8,
  parameter int CNT_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM*I_PREC-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM*O_PREC-1:0]   out_data;
  logic                    ovf_flag;
  logic                    udf_flag;
  logic                    rnd_flag;
  logic [CNT_W-1:0]        sat_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf_flag, udf_flag, rnd_flag, sat_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf_flag, udf_flag, rnd_flag, sat_cnt
  );
endinterface

// File: rtl/rdc_prec_ctrl_rdc_prec.sv
// Single-element fixed-point precision reduction: drop fraction bits by
// truncation (floor), clamp to the output range, report ovf/udf/rounded.
module rdc_prec
  import rdc_prec_ctrl_pkg::*;
#(
  parameter dconf_t I_CONF = I_CONF_DEF,
  parameter dconf_t O_CONF = O_CONF_DEF
) (
  input  logic [I_CONF.prec-1:0] in_i,
  output logic [O_CONF.prec-1:0] out_o,
  output logic                   ovf_o,
  output logic                   udf_o,
  output logic                   rounded_o
);
  localparam int IP = int'(I_CONF.prec);
  localparam int OP = int'(O_CONF.prec);
  localparam int SH = int'(I_CONF.frac) - int'(O_CONF.frac);
  localparam int W  = IP + 1;

  localparam logic signed [W-1:0] MAXV = O_CONF.sign ? W'((64'sd1 <<< (OP-1)) - 64'sd1)
                                                     : W'((64'sd1 <<< OP) - 64'sd1);
  localparam logic signed [W-1:0] MINV = O_CONF.sign ? W'(-(64'sd1 <<< (OP-1)))
                                                     : W'(64'sd0);
  localparam logic [IP-1:0]       LOST = IP'((64'd1 << SH) - 64'd1);

  logic signed [W-1:0] ext, shr;

  // one extra bit lets signed and unsigned inputs share the same signed compare
  assign ext       = {I_CONF.sign & in_i[IP-1], in_i};
  assign shr       = ext >>> SH;
  assign rounded_o = |(in_i & LOST);
  assign ovf_o     = shr > MAXV;
  assign udf_o     = shr < MINV;
  assign out_o     = ovf_o ? MAXV[OP-1:0] : (udf_o ? MINV[OP-1:0] : shr[OP-1:0]);

endmodule

// File: rtl/rdc_prec_ctrl.sv
// Time-multiplexes one rdc_prec across a NUM-lane batch, one lane per cycle,
// and gathers sticky ovf/udf/rounded flags and a saturating event count.
module rdc_prec_ctrl
  import rdc_prec_ctrl_pkg::*;
#(
  parameter dconf_t I_CONF = I_CONF_DEF,
  parameter dconf_t O_CONF = O_CONF_DEF,
  parameter int     NUM    = 8,
  parameter int     CNT_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  rdc_prec_ctrl_if.slave bus
);
  localparam int               I_PREC  = int'(I_CONF.prec);
  localparam int               O_PREC  = int'(O_CONF.prec);
  localparam int               IDX_W   = $clog2(NUM);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rdc_ctrl_state_t            state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM-1:0][I_PREC-1:0] ibuf_q, ibuf_d;
  logic [NUM-1:0][O_PREC-1:0] obuf_q, obuf_d;
  logic                       ovf_q, ovf_d, udf_q, udf_d, rnd_q, rnd_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic [I_PREC-1:0] lane_in;
  logic [O_PREC-1:0] lane_out;
  logic              lane_ovf, lane_udf, lane_rnd;
  logic              accept;

  assign bus.in_ready  = (state_q == RDC_IDLE) | ((state_q == RDC_DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign lane_in       = ibuf_q[idx_q];

  assign bus.out_valid = (state_q == RDC_DONE);
  assign bus.out_data  = obuf_q;
  assign bus.ovf_flag  = ovf_q;
  assign bus.udf_flag  = udf_q;
  assign bus.rnd_flag  = rnd_q;
  assign bus.sat_cnt   = cnt_q;

  rdc_prec #(.I_CONF(I_CONF), .O_CONF(O_CONF)) u_rdc (
    .in_i      (lane_in),
    .out_o     (lane_out),
    .ovf_o     (lane_ovf),
    .udf_o     (lane_udf),
    .rounded_o (lane_rnd)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ibuf_d  = ibuf_q;
    obuf_d  = obuf_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RDC_RUN: begin
        obuf_d[idx_q] = lane_out;
        ovf_d         = ovf_q | lane_ovf;
        udf_d         = udf_q | lane_udf;
        rnd_d         = rnd_q | lane_rnd;
        if ((lane_ovf | lane_udf) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        if (idx_q == LAST) state_d = RDC_DONE;
        else               idx_d   = idx_q + IDX_W'(1);
      end
      RDC_DONE: begin
        if (bus.out_ready && !bus.in_valid) state_d = RDC_IDLE;
      end
      default: state_d = RDC_IDLE;
    endcase
    // accept only fires from IDLE or DONE, so it cleanly overrides the hold above
    if (accept) begin
      ibuf_d  = bus.in_data;
      idx_d   = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      rnd_d   = 1'b0;
      cnt_d   = '0;
      state_d = RDC_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RDC_IDLE;
      idx_q   <= '0;
      ibuf_q  <= '0;
      obuf_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rnd_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ibuf_q  <= ibuf_d;
      obuf_q  <= obuf_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
